dsp_result_out: RTL

Output-side register and flow-control stage of the DSP slice: it accepts results (P bus plus carry-out) produced behind the input register stage, optionally registers them (PREG), and presents them downstream through a 2-entry skid buffer with a valid/ready handshake. Its `in_ready` is the clock-enable that stalls the upstream datapath when the consumer back-pressures. No result is ever dropped or duplicated.

---
 rtl/dsp_result_out.sv | 126 ++++++++++++
 1 files changed

// File: rtl/dsp_result_out.sv
`default_nettype none
// =============================================================================
// dsp_result_out : optional P register followed by a 2-entry skid buffer
//                  that carries DSP results (P bus + carry-out) downstream.
// Rev 1.0
// =============================================================================
module dsp_result_out #(
  parameter int WIDTH = 48,
  parameter int PREG  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_carry,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [WIDTH:0] main_q, skid_q;
  logic           skid_ready_q;
  logic           out_valid_q;
  logic [1:0]     occ_q;

  logic [WIDTH:0] in_word;
  logic [WIDTH:0] push_word;
  logic           push_valid;
  logic           push;
  logic           pop;
  logic           pv_d;
  logic [1:0]     buf_cnt_d;

  assign in_word = {in_carry, in_data};
  assign push    = push_valid && skid_ready_q;
  assign pop     = out_valid_q && out_ready;

  generate
    if (PREG != 0) begin : g_preg
      logic           p_v_q;
      logic [WIDTH:0] p_q;
      logic           in_xfer;

      assign in_xfer = in_valid && in_ready;
      // P is refilled in the same cycle it drains, so only skid_ready gates it
      assign pv_d    = in_xfer | (p_v_q & ~push);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p_v_q <= 1'b0;
          p_q   <= '0;
        end else begin
          if (in_xfer) p_q <= in_word;
          p_v_q <= pv_d;
        end
      end

      assign push_valid = p_v_q;
      assign push_word  = p_q;
      assign in_ready   = !p_v_q || skid_ready_q;
    end else begin : g_nopreg
      assign pv_d       = 1'b0;
      assign push_valid = in_valid;
      assign push_word  = in_word;
      assign in_ready   = skid_ready_q;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (push) state_d = S_ONE;
      S_ONE: begin
        if (push && !pop)      state_d = S_FULL;
        else if (!push && pop) state_d = S_EMPTY;
      end
      S_FULL:  if (pop) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  assign buf_cnt_d = (state_d == S_ONE)  ? 2'd1 :
                     (state_d == S_FULL) ? 2'd2 : 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      skid_ready_q <= 1'b1;
      out_valid_q  <= 1'b0;
      occ_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      skid_ready_q <= (state_d != S_FULL);
      out_valid_q  <= (state_d != S_EMPTY);
      occ_q        <= {1'b0, pv_d} + buf_cnt_d;
      case (state_q)
        S_EMPTY: if (push) main_q <= push_word;
        S_ONE: begin
          if (push && pop) main_q <= push_word;
          else if (push)   skid_q <= push_word;
        end
        S_FULL:  if (pop) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign out_data  = main_q[WIDTH-1:0];
  assign out_carry = main_q[WIDTH];
  assign out_valid = out_valid_q;
  assign occupancy = occ_q;

endmodule
`default_nettype wire
